// File: rtl/knapsack_pkg.sv
// knapsack_pkg: shared sizing, FSM state encoding and the item record used by
// the knapsack search controller and its combinational evaluator.
package knapsack_pkg;

  localparam int N_ITEMS = 5;
  localparam int ITEM_W  = 8;
  // Wide enough that the sum of N_ITEMS full-scale items never overflows.
  localparam int SUM_W   = ITEM_W + $clog2(N_ITEMS);
  localparam int IDX_W   = $clog2(N_ITEMS);

  // Final choice vector of a sweep (all items selected).
  localparam logic [N_ITEMS-1:0] LAST_CAND = '1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  typedef struct packed {
    logic [ITEM_W-1:0] weight;
    logic [ITEM_W-1:0] value;
  } item_t;

  typedef item_t [N_ITEMS-1:0] item_table_t;

endpackage

// File: rtl/knapsack_eval.sv
// knapsack_eval: purely combinational scorer for one choice vector.
// Ports:
//   choices   - candidate vector, bit i selects item i
//   items     - item weight/value table
//   capacity  - maximum allowed total weight (inclusive)
//   min_value - minimum required total value (inclusive)
//   weight    - total weight of the selected items
//   value     - total value of the selected items
//   fits      - weight <= capacity
//   meets     - value >= min_value
module knapsack_eval
  import knapsack_pkg::*;
(
  input  logic [N_ITEMS-1:0] choices,
  input  item_table_t        items,
  input  logic [SUM_W-1:0]   capacity,
  input  logic [SUM_W-1:0]   min_value,
  output logic [SUM_W-1:0]   weight,
  output logic [SUM_W-1:0]   value,
  output logic               fits,
  output logic               meets
);

  always_comb begin
    // NOTE: combinational accumulators use blocking assignments and get a
    // default before the loop, so every path assigns them and no latch forms.
    weight = '0;
    value  = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (choices[i]) begin
        weight = weight + SUM_W'(items[i].weight);
        value  = value  + SUM_W'(items[i].value);
      end
    end
    fits  = (weight <= capacity);
    meets = (value >= min_value);
  end

endmodule

// File: rtl/knapsack_search.sv
// knapsack_search: exhaustive 0-1 knapsack search controller.
// Sweeps every choice vector 0 .. 2^N_ITEMS-1, one per clock, and keeps the
// highest-value candidate that fits the capacity and meets the minimum value.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cfg_we/idx/weight/value - item table write port (ignored while scanning)
//   capacity, min_value   - search limits, captured when a search starts
//   start                 - single-cycle search request (honoured in IDLE only)
//   busy                  - high from the cycle after start through done
//   done                  - one-cycle pulse, results valid
//   found                 - some candidate satisfied both limits
//   best_choices/value/weight - winning candidate (all zero when not found)
module knapsack_search
  import knapsack_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [ITEM_W-1:0]  cfg_weight,
  input  logic [ITEM_W-1:0]  cfg_value,
  input  logic [SUM_W-1:0]   capacity,
  input  logic [SUM_W-1:0]   min_value,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_choices,
  output logic [SUM_W-1:0]   best_value,
  output logic [SUM_W-1:0]   best_weight
);

  state_t               state;
  logic [N_ITEMS-1:0]   cand;
  logic [SUM_W-1:0]     cap_q;
  logic [SUM_W-1:0]     minv_q;
  item_table_t          table_q;

  logic [SUM_W-1:0]     eval_weight;
  logic [SUM_W-1:0]     eval_value;
  logic                 eval_fits;
  logic                 eval_meets;
  logic                 take;

  knapsack_eval u_eval (
    .choices   (cand),
    .items     (table_q),
    .capacity  (cap_q),
    .min_value (minv_q),
    .weight    (eval_weight),
    .value     (eval_value),
    .fits      (eval_fits),
    .meets     (eval_meets)
  );

  // Strictly-greater replacement keeps the lowest index on a value tie,
  // because candidates are visited in ascending order.
  assign take = eval_fits && eval_meets && (!found || (eval_value > best_value));

  // Item table. Writes are blocked during a sweep so a search always sees one
  // consistent table; out-of-range indices match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is small register storage with a defined all-zero
      // power-on content, so it sits on the async reset like the FSM does.
      table_q <= '0;
    end else if (cfg_we && (state != SCAN)) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          table_q[i] <= '{weight: cfg_weight, value: cfg_value};
        end
      end
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cand         <= '0;
      cap_q        <= '0;
      minv_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      best_choices <= '0;
      best_value   <= '0;
      best_weight  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // in this block samples the pre-edge values, independent of order.
      case (state)
        IDLE: begin
          if (start) begin
            cap_q        <= capacity;
            minv_q       <= min_value;
            cand         <= '0;
            found        <= 1'b0;
            best_choices <= '0;
            best_value   <= '0;
            best_weight  <= '0;
            busy         <= 1'b1;
            // Candidate 0 is scored in the next cycle, so a table write
            // landing on the start edge is already visible to it.
            state        <= SCAN;
          end
        end

        SCAN: begin
          if (take) begin
            found        <= 1'b1;
            best_choices <= cand;
            best_value   <= eval_value;
            best_weight  <= eval_weight;
          end
          if (cand == LAST_CAND) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cand <= cand + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knapsack_search.sv
// Directed testbench for knapsack_search. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, away from the active edge.
module tb_knapsack_search;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [7:0]  cfg_weight;
  logic [7:0]  cfg_value;
  logic [10:0] capacity;
  logic [10:0] min_value;
  logic        start;
  logic        busy;
  logic        done;
  logic        found;
  logic [4:0]  best_choices;
  logic [10:0] best_value;
  logic [10:0] best_weight;

  int n_checks = 0;
  int n_fail   = 0;

  // {found, best_choices, best_value, best_weight}
  localparam logic [27:0] RES_S1    = {1'b1, 5'b11110, 11'd15, 11'd8};
  localparam logic [27:0] RES_NONE  = {1'b0, 5'b00000, 11'd0,  11'd0};
  localparam logic [27:0] RES_EMPTY = {1'b1, 5'b00000, 11'd0,  11'd0};
  localparam logic [27:0] RES_TIE   = {1'b1, 5'b00001, 11'd5,  11'd3};

  knapsack_search dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_weight   (cfg_weight),
    .cfg_value    (cfg_value),
    .capacity     (capacity),
    .min_value    (min_value),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .best_choices (best_choices),
    .best_value   (best_value),
    .best_weight  (best_weight)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] result();
    return {found, best_choices, best_value, best_weight};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_item(input logic [2:0] idx, input logic [7:0] w, input logic [7:0] v);
    cfg_we     = 1'b1;
    cfg_idx    = idx;
    cfg_weight = w;
    cfg_value  = v;
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic load_scenario1();
    load_item(3'd0, 8'd12, 8'd4);
    load_item(3'd1, 8'd1,  8'd2);
    load_item(3'd2, 8'd2,  8'd2);
    load_item(3'd3, 8'd1,  8'd1);
    load_item(3'd4, 8'd4,  8'd10);
  endtask

  // Pulses start, then waits (bounded) for done. lat is the start-to-done
  // latency in cycles; busy_gap flags busy dropping before done.
  task automatic run_search(input logic [10:0] cap, input logic [10:0] minv,
                            output int lat, output bit timed_out, output bit busy_gap);
    int n;
    capacity  = cap;
    min_value = minv;
    start     = 1'b1;
    step();
    start     = 1'b0;
    n         = 0;
    busy_gap  = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) busy_gap = 1'b1;
      step();
      n++;
    end
    lat       = n + 1;
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0; cfg_value = '0;
    capacity = '0; min_value = '0; start = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result()} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {busy, done, result()});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy/done got %b required 00", {busy, done});
    end
  endtask

  task automatic test_basic();
    int lat; bit to; bit gap;
    load_scenario1();
    run_search(11'd15, 11'd15, lat, to, gap);
    n_checks++;
    if (to || lat != 33) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d required 33 (timeout=%0b)", lat, to);
    end
    n_checks++;
    if (gap) begin
      n_fail++;
      $display("FAIL basic_busy_scan: busy got 0 during scan required 1");
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_done: got %b required 1", busy);
    end
    n_checks++;
    if (result() !== RES_S1) begin
      n_fail++;
      $display("FAIL basic_result: got %h required %h", result(), RES_S1);
    end
    step();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_done_pulse: busy/done got %b required 00", {busy, done});
    end
    n_checks++;
    if (result() !== RES_S1) begin
      n_fail++;
      $display("FAIL basic_hold: got %h required %h", result(), RES_S1);
    end
  endtask

  task automatic test_min_value_miss();
    int lat; bit to; bit gap;
    run_search(11'd15, 11'd16, lat, to, gap);
    n_checks++;
    if (to || result() !== RES_NONE) begin
      n_fail++;
      $display("FAIL min_value_miss: got %h required %h (timeout=%0b)", result(), RES_NONE, to);
    end
    step();
  endtask

  task automatic test_zero_capacity();
    int lat; bit to; bit gap;
    run_search(11'd0, 11'd0, lat, to, gap);
    n_checks++;
    if (to || result() !== RES_EMPTY) begin
      n_fail++;
      $display("FAIL zero_capacity: got %h required %h (timeout=%0b)", result(), RES_EMPTY, to);
    end
    step();
  endtask

  task automatic test_tie();
    int lat; bit to; bit gap;
    load_item(3'd0, 8'd3,   8'd5);
    load_item(3'd1, 8'd3,   8'd5);
    load_item(3'd2, 8'd200, 8'd1);
    load_item(3'd3, 8'd200, 8'd1);
    load_item(3'd4, 8'd200, 8'd1);
    // Out-of-range index: must not disturb any entry.
    load_item(3'd7, 8'd0,   8'd0);
    load_item(3'd5, 8'd0,   8'd0);
    run_search(11'd3, 11'd1, lat, to, gap);
    n_checks++;
    if (to || result() !== RES_TIE) begin
      n_fail++;
      $display("FAIL tie_lowest_index: got %h required %h (timeout=%0b)", result(), RES_TIE, to);
    end
    step();
  endtask

  task automatic test_scan_ignore();
    int n; int lat; bit to; bit gap;
    load_scenario1();
    capacity  = 11'd15;
    min_value = 11'd15;
    start     = 1'b1;
    step();
    start     = 1'b0;
    n         = 0;
    repeat (5) begin step(); n++; end
    // Mid-scan: start, table write and new limits must all be ignored.
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd4; cfg_weight = 8'd0; cfg_value = 8'd0;
    capacity = 11'd0; min_value = 11'd0;
    step(); n++;
    start = 1'b0; cfg_we = 1'b0;
    while (done !== 1'b1 && n < 100) begin step(); n++; end
    n_checks++;
    if (done !== 1'b1 || n + 1 != 33) begin
      n_fail++;
      $display("FAIL scan_ignore_latency: got %0d required 33", n + 1);
    end
    n_checks++;
    if (result() !== RES_S1) begin
      n_fail++;
      $display("FAIL scan_ignore_result: got %h required %h", result(), RES_S1);
    end
    // Back-to-back: start in the cycle right after done.
    step();
    run_search(11'd15, 11'd15, lat, to, gap);
    n_checks++;
    if (to || lat != 33 || result() !== RES_S1) begin
      n_fail++;
      $display("FAIL back_to_back: got %h lat %0d required %h lat 33", result(), lat, RES_S1);
    end
    step();
  endtask

  task automatic test_reset_mid_scan();
    int lat; bit to; bit gap; bit done_seen;
    load_scenario1();
    capacity  = 11'd15;
    min_value = 11'd0;
    start     = 1'b1;
    step();
    start     = 1'b0;
    repeat (9) step();
    // Candidate 1 (item A alone) already qualified, so results are non-zero.
    n_checks++;
    if (found !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: found/busy got %b%b required 11", found, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result()} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_mid_scan: got %h required 0", {busy, done, result()});
    end
    done_seen = 1'b0;
    repeat (3) begin
      step();
      if (done !== 1'b0) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      step();
      if (done !== 1'b0) done_seen = 1'b1;
    end
    n_checks++;
    if (done_seen) begin
      n_fail++;
      $display("FAIL reset_no_done: got done pulse required none");
    end
    // Cleared table: every candidate scores 0/0, so candidate 0 wins.
    run_search(11'd15, 11'd0, lat, to, gap);
    n_checks++;
    if (to || result() !== RES_EMPTY) begin
      n_fail++;
      $display("FAIL table_cleared: got %h required %h (timeout=%0b)", result(), RES_EMPTY, to);
    end
    step();
    load_scenario1();
    run_search(11'd15, 11'd15, lat, to, gap);
    n_checks++;
    if (to || lat != 33 || result() !== RES_S1) begin
      n_fail++;
      $display("FAIL reload_after_reset: got %h lat %0d required %h lat 33", result(), lat, RES_S1);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_value_miss();
    test_zero_capacity();
    test_tie();
    test_scan_ignore();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/knapsack_search.md
# knapsack_search

Sequencing controller for the 0-1 knapsack validity datapath. It holds a programmable table of item weights and values. On `start` it sweeps every choice vector from 0 to 2^N_ITEMS-1, one candidate per clock, through a combinational evaluator. It tracks the highest-value candidate that fits the capacity and meets the minimum value, and reports that candidate with a `done` pulse.

## Interface
- N_ITEMS, 5, number of items; candidate vector width
- ITEM_W, 8, width of each item weight/value
- SUM_W, ITEM_W+$clog2(N_ITEMS), width of weight/value sums; sums never overflow
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- cfg_we  in  1  item table write strobe
- cfg_idx  in  $clog2(N_ITEMS)  item index to write
- cfg_weight  in  ITEM_W  item weight
- cfg_value  in  ITEM_W  item value
- capacity  in  SUM_W  maximum total weight (inclusive), sampled at start
- min_value  in  SUM_W  minimum total value (inclusive), sampled at start
- start  in  1  single-cycle request to begin a search
- busy  out  1  search in progress
- done  out  1  one-cycle pulse when results are valid
- found  out  1  at least one candidate satisfied both limits
- best_choices  out  N_ITEMS  winning choice vector; bit i set means item i is chosen
- best_value  out  SUM_W  total value of the winner
- best_weight  out  SUM_W  total weight of the winner

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - `start`=1 latches `capacity` and `min_value`.
  - Clears `found`, `best_*` and the candidate counter.
  - Moves to SCAN.
- SCAN:
  - Counter value `cand` drives the evaluator.
  - Candidate is valid when `weight <= cap_q` and `value >= minv_q`.
  - A valid candidate whose value is strictly greater than the stored best, or any valid candidate while `found`=0, replaces `best_*` and sets `found`=1.
  - On a value tie, the lower candidate index wins.
  - When `cand` = 2^N_ITEMS-1 is evaluated, moves to DONE; the counter does not wrap.
- DONE:
  - `done`=1 for exactly one cycle, then IDLE.
  - Result outputs hold until the next accepted `start`.
- Item table:
  - `cfg_we` writes in IDLE and DONE only; writes during SCAN are ignored.
  - A write to `cfg_idx` >= N_ITEMS is ignored.
  - Table resets to all zeros.
- `start` outside IDLE is ignored; no queuing.
- When `found`=0 at DONE, `best_choices`, `best_value` and `best_weight` are 0.
- Simultaneous `start` and `cfg_we` in IDLE:
  - The write lands.
  - The search still uses the old table for cand 0 only if the table is read combinationally.
  - To avoid this, the first SCAN cycle is cand 0 in the cycle after `start`, so the new entry is visible.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `found`=0.
  - `best_choices`, `best_value`, `best_weight` = 0; counter 0; table 0.
- `start` is sampled at edge T. SCAN occupies T+1 .. T+2^N_ITEMS.
- `done` is high in cycle T+2^N_ITEMS+1. Latency start→done = 2^N_ITEMS+1 cycles (33 for N_ITEMS=5).
- `busy`=1 from T+1 through the DONE cycle inclusive.
- Best registers update at the edge ending each SCAN cycle. They are stable and valid when `done`=1.
- A `start` is accepted in the cycle after DONE, i.e. back-to-back searches.
- `rst_n` low mid-scan: state, outputs and table return to reset values immediately; no `done` is issued.

## Structure
- Package `knapsack_pkg`:
  - Parameters N_ITEMS, ITEM_W, SUM_W.
  - State enum (IDLE/SCAN/DONE).
  - `item_t` struct {weight, value}.
- Sub-module `knapsack_eval`: purely combinational. Inputs are the choice vector and item table; outputs are total weight, total value and fits/meets flags.
- Top holds the FSM, counter, table registers and best-tracking registers.

## Test plan
- Load items A(12,4), B(1,2), C(2,2), D(1,1), E(4,10) into idx 0-4; capacity=15, min_value=15; start → `done` 33 cycles later, found=1, best_choices=5'b11110, best_value=15, best_weight=8.
- Same table, min_value=16 → found=0, best_choices=0, best_value=0, best_weight=0.
- Same table, capacity=0, min_value=0 → found=1, best_choices=0, value 0, weight 0.
- Tie: idx0 and idx1 both (3,5), others (200,1), capacity=3, min_value=1 → best_choices=5'b00001, value 5, weight 3.
- Assert `start` and `cfg_we` (idx4 → (0,0)) during SCAN → both ignored; result identical to the first scenario; next `start` one cycle after `done` is accepted.
- Drop `rst_n` at SCAN cycle 10 → busy=0 and outputs 0 the same cycle; no `done`; table cleared; a fresh load and start reproduce the first scenario.
